iq_arbiter: RTL and testbench

IQ_ARBITER -- requirements
Module: iq_arbiter

---
 rtl/iq_arbiter_if.sv | 32 +++
 rtl/iq_arbiter.sv | 130 +++++++++++++
 tb/tb_iq_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iq_arbiter_if.sv
// IQ arbiter bus: N packed IQ source streams in, one tagged IQ stream out,
// plus grant status. slave = arbiter side, master = source/sink side.
interface iq_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int PORTS = 4
);
  localparam int DW = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORTS*WIDTH-1:0] input_i_tdata;
  logic [PORTS*WIDTH-1:0] input_q_tdata;
  logic [PORTS-1:0]       input_tvalid;
  logic [PORTS-1:0]       input_tready;
  logic [WIDTH-1:0]       output_i_tdata;
  logic [WIDTH-1:0]       output_q_tdata;
  logic [DW-1:0]          output_tdest;
  logic                   output_tvalid;
  logic                   output_tready;
  logic                   grant_valid;
  logic [DW-1:0]          grant_port;

  modport slave (
    input  input_i_tdata, input_q_tdata, input_tvalid, output_tready,
    output input_tready, output_i_tdata, output_q_tdata, output_tdest,
    output output_tvalid, grant_valid, grant_port
  );

  modport master (
    output input_i_tdata, input_q_tdata, input_tvalid, output_tready,
    input  input_tready, output_i_tdata, output_q_tdata, output_tdest,
    input  output_tvalid, grant_valid, grant_port
  );
endinterface

// File: rtl/iq_arbiter.sv
// Round-robin burst arbiter: grants one IQ port for up to BURST samples,
// forwards them through a single output register tagged with the source port.
module iq_arbiter #(
  parameter int WIDTH = 16,
  parameter int PORTS = 4,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  iq_arbiter_if.slave  bus
);
  localparam int DW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e             state_q, state_d;
  logic [DW-1:0]      grant_port_q, grant_port_d;
  logic [DW-1:0]      last_port_q, last_port_d;
  logic [CW-1:0]      burst_cnt_q, burst_cnt_d;
  logic               out_vld_q, out_vld_d;
  logic [WIDTH-1:0]   out_i_q, out_i_d;
  logic [WIDTH-1:0]   out_q_q, out_q_d;
  logic [DW-1:0]      out_dest_q, out_dest_d;

  logic [PORTS-1:0]   ready;
  logic               accept;
  logic               sel_found;
  logic [DW-1:0]      sel_port;

  // Rotating priority search starting just past the last served port
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_port  = '0;
    idx       = 0;
    for (int i = 0; i < PORTS; i++) begin
      idx = (int'(last_port_q) + 1 + i) % PORTS;
      if (!sel_found && bus.input_tvalid[idx]) begin
        sel_found = 1'b1;
        sel_port  = DW'(idx);
      end
    end
  end

  // Only the granted port sees ready, and only when the output slot can take a beat
  always_comb begin
    ready = '0;
    if (state_q == ACTIVE) ready[grant_port_q] = ~out_vld_q | bus.output_tready;
  end

  assign accept = (state_q == ACTIVE) && bus.input_tvalid[grant_port_q] && ready[grant_port_q];

  // Grant FSM and output register next-state
  always_comb begin
    state_d      = state_q;
    grant_port_d = grant_port_q;
    last_port_d  = last_port_q;
    burst_cnt_d  = burst_cnt_q;
    out_vld_d    = out_vld_q;
    out_i_d      = out_i_q;
    out_q_d      = out_q_q;
    out_dest_d   = out_dest_q;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_port_d = sel_port;
          burst_cnt_d  = '0;
          state_d      = ACTIVE;
        end
      end
      ACTIVE: begin
        // Source went away: release early; a stalled-but-valid port keeps the grant
        if (!bus.input_tvalid[grant_port_q]) begin
          state_d     = IDLE;
          last_port_d = grant_port_q;
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_q == CW'(BURST - 1)) begin
            state_d     = IDLE;
            last_port_d = grant_port_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept implies the slot is free or draining this cycle, so no overwrite
    if (accept) begin
      out_vld_d  = 1'b1;
      out_i_d    = bus.input_i_tdata[grant_port_q*WIDTH +: WIDTH];
      out_q_d    = bus.input_q_tdata[grant_port_q*WIDTH +: WIDTH];
      out_dest_d = grant_port_q;
    end else if (bus.output_tready) begin
      out_vld_d  = 1'b0;
    end
  end

  // State registers; reset leaves port 0 first in line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_port_q <= '0;
      last_port_q  <= DW'(PORTS - 1);
      burst_cnt_q  <= '0;
      out_vld_q    <= 1'b0;
      out_i_q      <= '0;
      out_q_q      <= '0;
      out_dest_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_port_q <= grant_port_d;
      last_port_q  <= last_port_d;
      burst_cnt_q  <= burst_cnt_d;
      out_vld_q    <= out_vld_d;
      out_i_q      <= out_i_d;
      out_q_q      <= out_q_d;
      out_dest_q   <= out_dest_d;
    end
  end

  assign bus.input_tready   = ready;
  assign bus.output_tvalid  = out_vld_q;
  assign bus.output_i_tdata = out_i_q;
  assign bus.output_q_tdata = out_q_q;
  assign bus.output_tdest   = out_dest_q;
  assign bus.grant_valid    = (state_q == ACTIVE);
  assign bus.grant_port     = grant_port_q;
endmodule

// File: tb/tb_iq_arbiter.sv
// Directed bench for iq_arbiter (WIDTH=16, PORTS=4, BURST=4).
// Each source port p emits I = {p, count}, Q = ~I; the sink logs accepted beats.
module tb_iq_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iq_arbiter_if #(.WIDTH(16), .PORTS(4)) bus ();
  iq_arbiter #(.WIDTH(16), .PORTS(4), .BURST(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0] src_en = 4'b0000;
  logic [7:0] lim [4];
  logic [7:0] cnt [4];

  logic [15:0] bi[$];
  logic [15:0] bq[$];
  logic [1:0]  bd[$];
  int          bc[$];

  for (genvar p = 0; p < 4; p++) begin : g_src
    assign bus.input_i_tdata[p*16 +: 16] = {8'(p), cnt[p]};
    assign bus.input_q_tdata[p*16 +: 16] = ~{8'(p), cnt[p]};
    assign bus.input_tvalid[p]           = src_en[p] && (cnt[p] < lim[p]);
  end

  // Source sample counters advance on each handshake
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 4; p++) cnt[p] <= 8'd0;
    end else begin
      cyc <= cyc + 1;
      for (int p = 0; p < 4; p++)
        if (bus.input_tvalid[p] && bus.input_tready[p]) cnt[p] <= cnt[p] + 8'd1;
    end
  end

  // Sink log: a beat is taken at the coming edge if valid & ready now
  always @(negedge clk) begin
    if (rst_n && bus.output_tvalid && bus.output_tready) begin
      bi.push_back(bus.output_i_tdata);
      bq.push_back(bus.output_q_tdata);
      bd.push_back(bus.output_tdest);
      bc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic clear_log();
    bi.delete(); bq.delete(); bd.delete(); bc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_en = 4'b0000;
    for (int p = 0; p < 4; p++) lim[p] = 8'd255;
    bus.output_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    src_en = 4'b1111;
    for (int p = 0; p < 4; p++) lim[p] = 8'd255;
    bus.output_tready = 1'b1;
    #1;
    checks++; if (bus.output_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", bus.output_tvalid); end
    checks++; if (bus.input_tready !== 4'b0000) begin errors++; $display("FAIL reset_tready got %b exp 0000", bus.input_tready); end
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_grant_valid got %b exp 0", bus.grant_valid); end
    checks++; if (bus.grant_port !== 2'd0) begin errors++; $display("FAIL reset_grant_port got %0d exp 0", bus.grant_port); end
    checks++; if (bus.output_tdest !== 2'd0) begin errors++; $display("FAIL reset_tdest got %0d exp 0", bus.output_tdest); end
    checks++; if (bus.output_i_tdata !== 16'h0) begin errors++; $display("FAIL reset_i got %h exp 0000", bus.output_i_tdata); end
    checks++; if (bus.output_q_tdata !== 16'h0) begin errors++; $display("FAIL reset_q got %h exp 0000", bus.output_q_tdata); end
    @(posedge clk); #1;
    checks++; if (bus.input_tready !== 4'b0000) begin errors++; $display("FAIL reset_held_tready got %b exp 0000", bus.input_tready); end
  endtask

  task automatic test_single_port();
    do_reset();
    src_en = 4'b0100;
    @(negedge clk);
    checks++; if (bus.input_tready !== 4'b0000) begin errors++; $display("FAIL idle_tready got %b exp 0000", bus.input_tready); end
    @(posedge clk); #1;
    checks++; if (bus.grant_valid !== 1'b1 || bus.grant_port !== 2'd2) begin errors++; $display("FAIL single_grant got %b/%0d exp 1/2", bus.grant_valid, bus.grant_port); end
    repeat (12) @(posedge clk); #1;
    checks++;
    if (bi.size() < 5) begin
      errors++; $display("FAIL single_count got %0d exp >=5", bi.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (bi[k] !== 16'h0200 + 16'(k)) begin errors++; $display("FAIL single_i[%0d] got %h exp %h", k, bi[k], 16'h0200 + 16'(k)); end
        checks++; if (bq[k] !== ~(16'h0200 + 16'(k))) begin errors++; $display("FAIL single_q[%0d] got %h exp %h", k, bq[k], ~(16'h0200 + 16'(k))); end
        checks++; if (bd[k] !== 2'd2) begin errors++; $display("FAIL single_dest[%0d] got %0d exp 2", k, bd[k]); end
      end
      for (int k = 1; k < 4; k++) begin
        checks++; if (bc[k] - bc[k-1] != 1) begin errors++; $display("FAIL single_spacing[%0d] got %0d exp 1", k, bc[k] - bc[k-1]); end
      end
      checks++; if (bc[4] - bc[3] != 2) begin errors++; $display("FAIL single_gap got %0d exp 2", bc[4] - bc[3]); end
    end
  endtask

  task automatic test_all_ports();
    logic [1:0] order [5];
    logic [1:0] ed;
    logic [15:0] ei;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
    do_reset();
    src_en = 4'b1111;
    repeat (30) @(posedge clk); #1;
    checks++;
    if (bi.size() < 20) begin
      errors++; $display("FAIL all_count got %0d exp >=20", bi.size());
    end else begin
      for (int b = 0; b < 20; b++) begin
        ed = order[b/4];
        ei = {6'd0, ed, 8'((b/16)*4 + b%4)};
        checks++; if (bd[b] !== ed) begin errors++; $display("FAIL all_dest[%0d] got %0d exp %0d", b, bd[b], ed); end
        checks++; if (bi[b] !== ei) begin errors++; $display("FAIL all_i[%0d] got %h exp %h", b, bi[b], ei); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit found;
    do_reset();
    src_en = 4'b0010;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(posedge clk); #1;
      if (bus.output_tvalid) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL bp_first_beat got none exp beat within 20 cycles");
    end else begin
      bus.output_tready = 1'b0;
      for (int t = 0; t < 5; t++) begin
        @(negedge clk);
        checks++; if (bus.output_tvalid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got %b exp 1", t, bus.output_tvalid); end
        checks++; if (bus.output_i_tdata !== 16'h0100) begin errors++; $display("FAIL bp_hold_i[%0d] got %h exp 0100", t, bus.output_i_tdata); end
        checks++; if (bus.output_tdest !== 2'd1) begin errors++; $display("FAIL bp_hold_dest[%0d] got %0d exp 1", t, bus.output_tdest); end
        checks++; if (bus.input_tready[1] !== 1'b0) begin errors++; $display("FAIL bp_tready[%0d] got %b exp 0", t, bus.input_tready[1]); end
        checks++; if (bus.grant_valid !== 1'b1) begin errors++; $display("FAIL bp_grant[%0d] got %b exp 1", t, bus.grant_valid); end
      end
      @(posedge clk); #1;
      bus.output_tready = 1'b1;
      repeat (10) @(posedge clk); #1;
      checks++;
      if (bi.size() < 6) begin
        errors++; $display("FAIL bp_count got %0d exp >=6", bi.size());
      end else begin
        for (int k = 0; k < 6; k++) begin
          checks++; if (bi[k] !== 16'h0100 + 16'(k)) begin errors++; $display("FAIL bp_i[%0d] got %h exp %h", k, bi[k], 16'h0100 + 16'(k)); end
          checks++; if (bd[k] !== 2'd1) begin errors++; $display("FAIL bp_dest[%0d] got %0d exp 1", k, bd[k]); end
        end
      end
    end
  endtask

  task automatic test_early_release();
    logic [15:0] ei [6];
    logic [1:0]  ed [6];
    int          ones;
    int          first;
    ei[0] = 16'h0100; ei[1] = 16'h0101; ei[2] = 16'h0300; ei[3] = 16'h0301; ei[4] = 16'h0302; ei[5] = 16'h0303;
    ed[0] = 2'd1; ed[1] = 2'd1; ed[2] = 2'd3; ed[3] = 2'd3; ed[4] = 2'd3; ed[5] = 2'd3;
    do_reset();
    src_en = 4'b1010;
    lim[1] = 8'd2;
    repeat (14) @(posedge clk); #1;
    checks++;
    if (bi.size() < 6) begin
      errors++; $display("FAIL er_count got %0d exp >=6", bi.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++; if (bi[k] !== ei[k] || bd[k] !== ed[k]) begin errors++; $display("FAIL er_beat[%0d] got %h/%0d exp %h/%0d", k, bi[k], bd[k], ei[k], ed[k]); end
      end
      ones = 0;
      for (int k = 2; k < bi.size(); k++) if (bd[k] == 2'd1) ones++;
      checks++; if (ones != 0) begin errors++; $display("FAIL er_port1_after_release got %0d beats exp 0", ones); end
    end
    lim[1] = 8'd255;
    repeat (25) @(posedge clk); #1;
    first = -1;
    for (int k = 2; k < bi.size(); k++) if (first < 0 && bd[k] == 2'd1) first = k;
    checks++;
    if (first < 0 || first + 4 > bi.size()) begin
      errors++; $display("FAIL er_regrant got index %0d exp full port1 burst", first);
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++; if (bd[first+j] !== 2'd1 || bi[first+j] !== 16'h0102 + 16'(j)) begin
          errors++; $display("FAIL er_regrant[%0d] got %h/%0d exp %h/1", j, bi[first+j], bd[first+j], 16'h0102 + 16'(j));
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    src_en = 4'b0100;
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.output_tvalid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got %b exp 1", bus.output_tvalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.output_tvalid !== 1'b0) begin errors++; $display("FAIL rm_async_valid got %b exp 0", bus.output_tvalid); end
    checks++; if (bus.input_tready !== 4'b0000) begin errors++; $display("FAIL rm_async_tready got %b exp 0000", bus.input_tready); end
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL rm_async_grant got %b exp 0", bus.grant_valid); end
    src_en = 4'b1111;
    @(posedge clk); #1 rst_n = 1'b1;
    clear_log();
    repeat (8) @(posedge clk); #1;
    checks++;
    if (bi.size() < 4) begin
      errors++; $display("FAIL rm_count got %0d exp >=4", bi.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (bd[k] !== 2'd0 || bi[k] !== 16'(k)) begin errors++; $display("FAIL rm_beat[%0d] got %h/%0d exp %h/0", k, bi[k], bd[k], 16'(k)); end
      end
    end
  endtask

  initial begin
    bus.output_tready = 1'b1;
    for (int p = 0; p < 4; p++) lim[p] = 8'd255;
    test_reset();
    test_single_port();
    test_all_ports();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
